// File: rtl/pb_irq_pkg.sv
// Shared definitions for the PicoBlaze interrupt controller: FSM states,
// default I/O port addresses and the cause register layout.
package pb_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_ACKED  = 2'd2
  } irq_state_t;

  localparam logic [7:0] DEF_PORT_MASK  = 8'h10;
  localparam logic [7:0] DEF_PORT_PEND  = 8'h11;
  localparam logic [7:0] DEF_PORT_CAUSE = 8'h12;
  localparam logic [7:0] DEF_PORT_OVR   = 8'h13;

  localparam int CAUSE_VALID_BIT = 7;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-index-wins priority encoder over eight request lines.
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = 3'd0;
    any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pb_irq_ctrl.sv
// Edge-triggered interrupt controller for kcpsm6. Collects rising edges on
// up to eight sources into a pending register, raises `interrupt` for the
// lowest-index enabled source and records which one was serviced in the
// cause register when the processor acknowledges.
module pb_irq_ctrl
  import pb_irq_pkg::*;
#(
  parameter int         NUM_SRC    = 4,
  parameter logic [7:0] PORT_MASK  = DEF_PORT_MASK,
  parameter logic [7:0] PORT_PEND  = DEF_PORT_PEND,
  parameter logic [7:0] PORT_CAUSE = DEF_PORT_CAUSE,
  parameter logic [7:0] PORT_OVR   = DEF_PORT_OVR
) (
  input  logic               sysclk,
  input  logic               sysreset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic [7:0]         io_data_in,
  output logic [7:0]         io_data_out,
  output logic               interrupt,
  input  logic               interrupt_ack
);

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] overrun;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pend_w1c;
  logic [NUM_SRC-1:0] ovr_w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [7:0]         enabled;
  logic [7:0]         ack_onehot;
  logic [2:0]         win_idx;
  logic               win_any;
  logic               cause_valid;
  logic [2:0]         cause_idx;
  logic               ack_take;
  logic               wr_mask;
  logic               wr_pend;
  logic               wr_ovr;
  logic               rd_cause;
  irq_state_t         state;
  irq_state_t         state_next;
  logic               unused_bits;

  assign rise     = irq_src & ~src_q;
  assign wr_mask  = write_strobe && (port_id == PORT_MASK);
  assign wr_pend  = write_strobe && (port_id == PORT_PEND);
  assign wr_ovr   = write_strobe && (port_id == PORT_OVR);
  assign rd_cause = read_strobe && (port_id == PORT_CAUSE);
  assign pend_w1c = wr_pend ? io_data_in[NUM_SRC-1:0] : '0;
  assign ovr_w1c  = wr_ovr ? io_data_in[NUM_SRC-1:0] : '0;

  assign ack_onehot = 8'b1 << win_idx;
  assign ack_clr    = ack_take ? ack_onehot[NUM_SRC-1:0] : '0;

  // Bits of the write bus and one-hot above NUM_SRC carry no meaning.
  assign unused_bits = ^{io_data_in, ack_onehot};

  // Widen the enabled-pending vector to the encoder's fixed 8-bit input.
  always_comb begin
    enabled = '0;
    enabled[NUM_SRC-1:0] = pending & mask;
  end

  prio_enc8 u_prio (
    .req (enabled),
    .idx (win_idx),
    .any (win_any)
  );

  // Request handshake: the winner is taken from the ack cycle itself, and a
  // request whose enabled sources all vanish is withdrawn silently.
  always_comb begin
    state_next = state;
    ack_take   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_any) state_next = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!win_any) begin
          state_next = ST_IDLE;
        end else if (interrupt_ack) begin
          ack_take   = 1'b1;
          state_next = ST_ACKED;
        end
      end
      ST_ACKED: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register; interrupt is registered so kcpsm6 sees a clean level.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
    end else begin
      state     <= state_next;
      interrupt <= (state_next == ST_ASSERT);
    end
  end

  // Edge history, pending/overrun bookkeeping and mask; new events win over
  // clears landing in the same cycle.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      src_q   <= irq_src;
      pending <= '0;
      overrun <= '0;
      mask    <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~(pend_w1c | ack_clr)) | rise;
      overrun <= (overrun & ~ovr_w1c) | (rise & pending);
      if (wr_mask) mask <= io_data_in[NUM_SRC-1:0];
    end
  end

  // Cause register: an ack records the winner; reading it drops valid only.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      cause_valid <= 1'b0;
      cause_idx   <= 3'd0;
    end else if (ack_take) begin
      cause_valid <= 1'b1;
      cause_idx   <= win_idx;
    end else if (rd_cause) begin
      cause_valid <= 1'b0;
    end
  end

  // Combinational read mux; unmapped ports return zero for OR-ing into in_port.
  always_comb begin
    io_data_out = 8'h00;
    case (port_id)
      PORT_MASK:  io_data_out[NUM_SRC-1:0] = mask;
      PORT_PEND:  io_data_out[NUM_SRC-1:0] = pending;
      PORT_OVR:   io_data_out[NUM_SRC-1:0] = overrun;
      PORT_CAUSE: begin
        io_data_out[CAUSE_VALID_BIT] = cause_valid;
        io_data_out[2:0]             = cause_idx;
      end
      default:    io_data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_pb_irq_ctrl.sv
// Self-checking bench for pb_irq_ctrl: directed scenarios followed by random
// traffic, with expectations queued per cycle and compared by a monitor.
module tb_pb_irq_ctrl;

  localparam int         NUM_SRC  = 4;
  localparam logic [7:0] SRC_BITS = 8'h0F;
  localparam logic [7:0] P_MASK   = 8'h10;
  localparam logic [7:0] P_PEND   = 8'h11;
  localparam logic [7:0] P_CAUSE  = 8'h12;
  localparam logic [7:0] P_OVR    = 8'h13;

  logic               sysclk = 1'b0;
  logic               sysreset = 1'b1;
  logic [NUM_SRC-1:0] irq_src = '0;
  logic [7:0]         port_id = 8'h00;
  logic               write_strobe = 1'b0;
  logic               read_strobe = 1'b0;
  logic [7:0]         io_data_in = 8'h00;
  logic [7:0]         io_data_out;
  logic               interrupt;
  logic               interrupt_ack = 1'b0;

  always #5 sysclk = ~sysclk;

  pb_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .irq_src       (irq_src),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .io_data_in    (io_data_in),
    .io_data_out   (io_data_out),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  typedef struct {
    logic       chk_rd;
    logic [7:0] port;
    logic [7:0] exp_rd;
    logic       exp_int;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: register contents plus the request line phase
  // (0 = quiet, 1 = requesting, 2 = post-ack gap cycle).
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_mask = 8'h00;
  logic [7:0] m_ovr  = 8'h00;
  logic       m_cv   = 1'b0;
  logic [2:0] m_ci   = 3'd0;
  int         m_phase = 0;
  logic [3:0] cur_src = 4'b0000;

  function automatic logic [7:0] model_read(input logic [7:0] p);
    if (p == P_MASK)  return m_mask;
    if (p == P_PEND)  return m_pend;
    if (p == P_OVR)   return m_ovr;
    if (p == P_CAUSE) return {m_cv, 4'b0000, m_ci};
    return 8'h00;
  endfunction

  task automatic model_update(input logic [3:0] src, input logic [7:0] port,
                              input logic ws, input logic rs,
                              input logic [7:0] din, input logic ack,
                              input logic rst);
    logic [7:0] rise, en, clr, oclr;
    int win;
    logic took;
    if (rst) begin
      m_prev = {4'b0000, src};
      m_pend = 8'h00; m_mask = 8'h00; m_ovr = 8'h00;
      m_cv = 1'b0; m_ci = 3'd0; m_phase = 0;
    end else begin
      rise = {4'b0000, src} & ~m_prev;
      en = m_pend & m_mask;
      win = -1;
      for (int i = 0; i < 8; i++) if (en[i] && win < 0) win = i;
      took = 1'b0;
      if (m_phase == 1) begin
        if (win < 0) m_phase = 0;
        else if (ack) begin took = 1'b1; m_phase = 2; end
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (win >= 0) begin
        m_phase = 1;
      end
      clr  = (ws && port == P_PEND) ? din : 8'h00;
      if (took) clr = clr | (8'b1 << win);
      oclr = (ws && port == P_OVR) ? din : 8'h00;
      m_ovr  = ((m_ovr & ~oclr) | (rise & m_pend)) & SRC_BITS;
      m_pend = ((m_pend & ~clr) | rise) & SRC_BITS;
      if (ws && port == P_MASK) m_mask = din & SRC_BITS;
      if (took) begin m_cv = 1'b1; m_ci = 3'(win); end
      else if (rs && port == P_CAUSE) m_cv = 1'b0;
      m_prev = {4'b0000, src};
    end
  endtask

  // One clock of stimulus; exp_rd >= 0 replaces the model's read value.
  task automatic applyStimulus(input logic [3:0] src, input logic [7:0] port,
                               input logic ws, input logic rs,
                               input logic [7:0] din, input logic ack,
                               input logic rst, input int exp_rd);
    exp_t e;
    irq_src = src; port_id = port; write_strobe = ws; read_strobe = rs;
    io_data_in = din; interrupt_ack = ack; sysreset = rst;
    e.chk_rd  = rs;
    e.port    = port;
    e.exp_rd  = (exp_rd >= 0) ? 8'(exp_rd) : model_read(port);
    e.exp_int = (m_phase == 1);
    exp_q.push_back(e);
    @(posedge sysclk);
    model_update(src, port, ws, rs, din, ack, rst);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] got,
                             input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s got %02h want %02h at %0t", name, got, want, $time);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) applyStimulus(cur_src, 8'h00, 0, 0, 8'h00, 0, 0, -1);
  endtask
  task automatic setsrc(input logic [3:0] s);
    cur_src = s;
    nop(1);
  endtask
  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    applyStimulus(cur_src, p, 1, 0, d, 0, 0, -1);
  endtask
  task automatic rd(input logic [7:0] p, input int exp);
    applyStimulus(cur_src, p, 0, 1, 8'h00, 0, 0, exp);
  endtask
  task automatic ack1();
    applyStimulus(cur_src, 8'h00, 0, 0, 8'h00, 1, 0, -1);
  endtask

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("interrupt", {7'b0, interrupt}, {7'b0, e.exp_int});
        if (e.chk_rd) begin
          case (e.port)
            P_MASK:  checkOutput("read_mask", io_data_out, e.exp_rd);
            P_PEND:  checkOutput("read_pend", io_data_out, e.exp_rd);
            P_CAUSE: checkOutput("read_cause", io_data_out, e.exp_rd);
            P_OVR:   checkOutput("read_ovr", io_data_out, e.exp_rd);
            default: checkOutput("read_unmapped", io_data_out, e.exp_rd);
          endcase
        end
      end
    end
  end

  initial begin
    logic [7:0] p;
    logic       ws, rs, ack, rst;
    @(posedge sysclk);
    #1;

    // Reset with a source already high: it must not become an event.
    cur_src = 4'b0010;
    applyStimulus(cur_src, 8'h00, 0, 0, 8'h00, 0, 1, -1);
    applyStimulus(cur_src, 8'h00, 0, 0, 8'h00, 0, 1, -1);
    wr(P_MASK, 8'h0F);
    nop(3);
    rd(P_PEND, 8'h00);
    setsrc(4'b0000);

    // Single source, ack, cause valid then cleared by reading.
    setsrc(4'b0100);
    setsrc(4'b0000);
    ack1();
    rd(P_CAUSE, 8'h82);
    rd(P_PEND, 8'h00);
    rd(P_CAUSE, 8'h02);

    // Two simultaneous sources are served lowest first.
    setsrc(4'b1010);
    setsrc(4'b0000);
    ack1();
    rd(P_CAUSE, 8'h81);
    rd(P_PEND, 8'h08);
    ack1();
    rd(P_CAUSE, 8'h83);

    // Masked source pends silently, then is withdrawn by W1C before ack.
    wr(P_MASK, 8'h00);
    setsrc(4'b0001);
    setsrc(4'b0000);
    rd(P_PEND, 8'h01);
    wr(P_MASK, 8'h01);
    nop(1);
    wr(P_PEND, 8'h01);
    nop(2);
    rd(P_CAUSE, 8'h03);

    // Overrun: set by a second event, survives a coinciding clear.
    wr(P_MASK, 8'h00);
    setsrc(4'b0001);
    setsrc(4'b0000);
    setsrc(4'b0001);
    setsrc(4'b0000);
    rd(P_OVR, 8'h01);
    cur_src = 4'b0001;
    applyStimulus(cur_src, P_OVR, 1, 0, 8'h01, 0, 0, -1);
    cur_src = 4'b0000;
    rd(P_OVR, 8'h01);
    wr(P_OVR, 8'h01);
    rd(P_OVR, 8'h00);

    // Reset while requesting.
    wr(P_MASK, 8'h01);
    nop(3);
    applyStimulus(cur_src, 8'h00, 0, 0, 8'h00, 0, 1, -1);
    rd(P_MASK, 8'h00);
    rd(P_PEND, 8'h00);
    rd(P_CAUSE, 8'h00);
    rd(P_OVR, 8'h00);
    rd(8'h55, 8'h00);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) cur_src = 4'($urandom);
      case ($urandom_range(0, 4))
        0: p = P_MASK;
        1: p = P_PEND;
        2: p = P_CAUSE;
        3: p = P_OVR;
        default: p = 8'($urandom);
      endcase
      ws  = ($urandom_range(0, 9) == 0);
      rs  = !ws && ($urandom_range(0, 2) == 0);
      ack = (m_phase == 1) && ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(cur_src, p, ws, rs, 8'($urandom), ack, rst, -1);
    end
    nop(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
